// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage between the program counter and the decoder.
// Issues one request per instruction over a valid/ready memory interface and
// holds the returned word until the decoder takes it. It pulses incPC on each
// fetch that is kept. A flush discards any in-flight or held instruction. A
// request the memory already accepted is drained before a new fetch starts.
module fetch_unit #(
  parameter int INSTMEM_ADDR_WIDTH = 16,
  parameter int INST_WIDTH         = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [INSTMEM_ADDR_WIDTH-1:0] pc_addr,
  output logic                          incPC,
  input  logic                          halt,
  input  logic                          flush,
  output logic                          mem_req_valid,
  output logic [INSTMEM_ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                          mem_req_ready,
  input  logic                          mem_rsp_valid,
  input  logic [INST_WIDTH-1:0]         mem_rsp_data,
  output logic                          inst_valid,
  output logic [INST_WIDTH-1:0]         inst,
  output logic [INSTMEM_ADDR_WIDTH-1:0] inst_pc,
  input  logic                          inst_ready,
  output logic                          busy
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  state_t                          state_r;
  state_t                          next_s;
  logic                            load_pc_s;
  logic                            capture_s;
  logic [INSTMEM_ADDR_WIDTH-1:0]   fetch_pc_r;
  logic [INST_WIDTH-1:0]           inst_r;
  logic [INSTMEM_ADDR_WIDTH-1:0]   inst_pc_r;

  // State register; reset always lands in IDLE so late responses become strays.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state decode plus the strobes that load the fetch address and capture data.
  always_comb begin
    next_s    = state_r;
    load_pc_s = 1'b0;
    capture_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!halt && !flush) begin
          next_s    = ST_REQ;
          load_pc_s = 1'b1;
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        // Memory samples only on valid&ready, so an unaccepted request may be withdrawn.
        if (mem_req_ready && !flush) begin
          next_s = ST_WAIT;
        end else if (mem_req_ready) begin
          next_s = ST_DRAIN;
        end else if (flush) begin
          next_s = ST_IDLE;
        end else begin
          next_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (mem_rsp_valid && !flush) begin
          next_s    = ST_HOLD;
          capture_s = 1'b1;
        end else if (mem_rsp_valid) begin
          next_s = ST_IDLE;
        end else if (flush) begin
          next_s = ST_DRAIN;
        end else begin
          next_s = ST_WAIT;
        end
      end
      ST_HOLD: begin
        // Flush beats inst_ready: the held word must not be handed over on a redirect.
        if (flush) begin
          next_s = ST_IDLE;
        end else if (inst_ready && !halt) begin
          next_s    = ST_REQ;
          load_pc_s = 1'b1;
        end else if (inst_ready) begin
          next_s = ST_IDLE;
        end else begin
          next_s = ST_HOLD;
        end
      end
      ST_DRAIN: begin
        if (mem_rsp_valid) begin
          next_s = ST_IDLE;
        end else begin
          next_s = ST_DRAIN;
        end
      end
      default: begin
        next_s = ST_IDLE;
      end
    endcase
  end

  // Fetch address and held instruction; pc_addr is taken verbatim, wrap is the PC's job.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_r <= {INSTMEM_ADDR_WIDTH{1'b0}};
      inst_r     <= {INST_WIDTH{1'b0}};
      inst_pc_r  <= {INSTMEM_ADDR_WIDTH{1'b0}};
    end else begin
      if (load_pc_s) begin
        fetch_pc_r <= pc_addr;
      end
      if (capture_s) begin
        inst_r    <= mem_rsp_data;
        inst_pc_r <= fetch_pc_r;
      end
    end
  end

  // incPC is the only input-dependent output; it can never coincide with flush.
  always_comb begin
    incPC = (state_r == ST_WAIT) && mem_rsp_valid && !flush;
  end

  assign mem_req_valid = (state_r == ST_REQ);
  assign mem_req_addr  = fetch_pc_r;
  assign inst_valid    = (state_r == ST_HOLD);
  assign inst          = inst_r;
  assign inst_pc       = inst_pc_r;
  assign busy          = (state_r != ST_IDLE);

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios with cycle-exact checks, then a randomized run.
// The randomized run checks against a transaction-level model of the PC, the
// memory and the decoder.
module tb_fetch_unit;
  localparam int AW = 16;
  localparam int IW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] pc_addr;
  logic          incPC;
  logic          halt;
  logic          flush;
  logic          mem_req_valid;
  logic [AW-1:0] mem_req_addr;
  logic          mem_req_ready;
  logic          mem_rsp_valid;
  logic [IW-1:0] mem_rsp_data;
  logic          inst_valid;
  logic [IW-1:0] inst;
  logic [AW-1:0] inst_pc;
  logic          inst_ready;
  logic          busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_unit #(.INSTMEM_ADDR_WIDTH(AW), .INST_WIDTH(IW)) dut (
    .clk(clk), .reset(reset), .pc_addr(pc_addr), .incPC(incPC), .halt(halt),
    .flush(flush), .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data), .inst_valid(inst_valid), .inst(inst),
    .inst_pc(inst_pc), .inst_ready(inst_ready), .busy(busy)
  );

  function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
    return {a ^ 16'h5A5A, a};
  endfunction

  task automatic adv();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    halt = 1'b1; flush = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    mem_rsp_data = 32'h0; inst_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    adv();
    reset = 1'b1;
    adv();
  endtask

  task automatic test_reset();
    idle_inputs();
    pc_addr = 16'h1234;
    reset = 1'b0;
    adv();
    #1;
    checks++;
    if ({busy, mem_req_valid, incPC, inst_valid} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b exp 0000", {busy, mem_req_valid, incPC, inst_valid});
    end
    checks++;
    if ({mem_req_addr, inst, inst_pc} !== 64'h0) begin
      errors++; $display("FAIL reset_data got %h/%h/%h exp 0", mem_req_addr, inst, inst_pc);
    end
    reset = 1'b1;
    adv();
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_halted_idle busy got %b exp 0", busy);
    end
  endtask

  task automatic test_zero_wait();
    do_reset();
    pc_addr = 16'h0010; halt = 1'b0; mem_req_ready = 1'b1;
    adv();
    #1;
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 16'h0010 || incPC !== 1'b0) begin
      errors++; $display("FAIL zw_cycle1 valid %b addr %h inc %b exp 1 0010 0", mem_req_valid, mem_req_addr, incPC);
    end
    adv();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEADBEEF;
    #1;
    checks++;
    if (incPC !== 1'b1 || inst_valid !== 1'b0) begin
      errors++; $display("FAIL zw_cycle2 inc %b ivalid %b exp 1 0", incPC, inst_valid);
    end
    adv();
    mem_rsp_valid = 1'b0; pc_addr = 16'h0011; inst_ready = 1'b1;
    #1;
    checks++;
    if (inst_valid !== 1'b1 || inst !== 32'hDEADBEEF || inst_pc !== 16'h0010 || incPC !== 1'b0) begin
      errors++; $display("FAIL zw_cycle3 v %b inst %h pc %h inc %b exp 1 deadbeef 0010 0", inst_valid, inst, inst_pc, incPC);
    end
    adv();
    inst_ready = 1'b0; halt = 1'b1;
    #1;
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 16'h0011 || inst_valid !== 1'b0) begin
      errors++; $display("FAIL zw_next_req valid %b addr %h exp 1 0011", mem_req_valid, mem_req_addr);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    pc_addr = 16'h0200; halt = 1'b0; mem_req_ready = 1'b0;
    adv();
    halt = 1'b1; pc_addr = 16'h0300;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 16'h0200) begin
        errors++; $display("FAIL bp_stall%0d valid %b addr %h exp 1 0200", i, mem_req_valid, mem_req_addr);
      end
      adv();
    end
    mem_req_ready = 1'b1;
    #1;
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 16'h0200) begin
      errors++; $display("FAIL bp_accept valid %b addr %h exp 1 0200", mem_req_valid, mem_req_addr);
    end
    adv();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'hCAFE0200;
    #1;
    checks++;
    if (mem_req_valid !== 1'b0 || busy !== 1'b1 || incPC !== 1'b1) begin
      errors++; $display("FAIL bp_wait valid %b busy %b inc %b exp 0 1 1", mem_req_valid, busy, incPC);
    end
    adv();
    mem_rsp_valid = 1'b0;
    #1;
    checks++;
    if (inst_valid !== 1'b1 || inst !== 32'hCAFE0200 || inst_pc !== 16'h0200) begin
      errors++; $display("FAIL bp_hold v %b inst %h pc %h exp 1 cafe0200 0200", inst_valid, inst, inst_pc);
    end
  endtask

  task automatic test_decoder_stall();
    int inc_cnt;
    inc_cnt = 0;
    do_reset();
    pc_addr = 16'h0040; halt = 1'b0; mem_req_ready = 1'b1;
    adv();
    #1; inc_cnt += int'(incPC);
    adv();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h13572468;
    #1; inc_cnt += int'(incPC);
    adv();
    mem_rsp_valid = 1'b0; pc_addr = 16'h0041; inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1; inc_cnt += int'(incPC);
      checks++;
      if (inst_valid !== 1'b1 || inst !== 32'h13572468 || inst_pc !== 16'h0040 || mem_req_valid !== 1'b0) begin
        errors++; $display("FAIL stall%0d v %b inst %h pc %h req %b exp 1 13572468 0040 0", i, inst_valid, inst, inst_pc, mem_req_valid);
      end
      adv();
    end
    inst_ready = 1'b1; halt = 1'b1;
    #1; inc_cnt += int'(incPC);
    adv();
    inst_ready = 1'b0;
    #1; inc_cnt += int'(incPC);
    checks++;
    if (busy !== 1'b0 || inc_cnt != 1) begin
      errors++; $display("FAIL stall_end busy %b incPC_pulses %0d exp 0 1", busy, inc_cnt);
    end
  endtask

  task automatic test_flush_wait();
    do_reset();
    pc_addr = 16'h0080; halt = 1'b0; mem_req_ready = 1'b1;
    adv();
    halt = 1'b1;
    adv();
    mem_req_ready = 1'b0; flush = 1'b1;
    #1;
    checks++;
    if (incPC !== 1'b0) begin
      errors++; $display("FAIL fw_flush inc got %b exp 0", incPC);
    end
    adv();
    flush = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b1 || inst_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
      errors++; $display("FAIL fw_drain busy %b v %b req %b exp 1 0 0", busy, inst_valid, mem_req_valid);
    end
    adv();
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hBAD0BAD0;
    #1;
    checks++;
    if (incPC !== 1'b0 || inst_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL fw_late_rsp inc %b v %b busy %b exp 0 0 1", incPC, inst_valid, busy);
    end
    adv();
    mem_rsp_valid = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || inst_valid !== 1'b0) begin
      errors++; $display("FAIL fw_idle busy %b v %b exp 0 0", busy, inst_valid);
    end
  endtask

  task automatic test_flush_coincident();
    do_reset();
    pc_addr = 16'h0090; halt = 1'b0; mem_req_ready = 1'b1;
    adv();
    halt = 1'b1;
    adv();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; flush = 1'b1; mem_rsp_data = 32'h0000_0090;
    #1;
    checks++;
    if (incPC !== 1'b0) begin
      errors++; $display("FAIL fc_wait inc got %b exp 0", incPC);
    end
    adv();
    mem_rsp_valid = 1'b0; flush = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || inst_valid !== 1'b0) begin
      errors++; $display("FAIL fc_idle busy %b v %b exp 0 0", busy, inst_valid);
    end
    pc_addr = 16'h00A0; halt = 1'b0; mem_req_ready = 1'b1;
    adv();
    adv();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_00A0;
    adv();
    mem_rsp_valid = 1'b0; pc_addr = 16'h00A1; flush = 1'b1; inst_ready = 1'b1;
    #1;
    checks++;
    if (inst_valid !== 1'b1 || inst !== 32'h0000_00A0) begin
      errors++; $display("FAIL fc_hold v %b inst %h exp 1 000000a0", inst_valid, inst);
    end
    adv();
    flush = 1'b0; inst_ready = 1'b0; halt = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || mem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
      errors++; $display("FAIL fc_hold_flush busy %b req %b v %b exp 0 0 0", busy, mem_req_valid, inst_valid);
    end
  endtask

  task automatic test_halt();
    do_reset();
    pc_addr = 16'h0100; halt = 1'b0; mem_req_ready = 1'b1;
    adv();
    adv();
    mem_req_ready = 1'b0; halt = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0100_0100;
    #1;
    checks++;
    if (incPC !== 1'b1) begin
      errors++; $display("FAIL halt_wait inc got %b exp 1", incPC);
    end
    adv();
    mem_rsp_valid = 1'b0; pc_addr = 16'h0101; inst_ready = 1'b1;
    #1;
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 16'h0100) begin
      errors++; $display("FAIL halt_hold v %b pc %h exp 1 0100", inst_valid, inst_pc);
    end
    adv();
    inst_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (busy !== 1'b0 || mem_req_valid !== 1'b0) begin
        errors++; $display("FAIL halt_idle%0d busy %b req %b exp 0 0", i, busy, mem_req_valid);
      end
      adv();
    end
    halt = 1'b0;
    adv();
    halt = 1'b1;
    #1;
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 16'h0101) begin
      errors++; $display("FAIL halt_resume req %b addr %h exp 1 0101", mem_req_valid, mem_req_addr);
    end
  endtask

  task automatic test_reset_midop();
    do_reset();
    pc_addr = 16'h0300; halt = 1'b0; mem_req_ready = 1'b1;
    adv();
    adv();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1111_2222;
    adv();
    mem_rsp_valid = 1'b0; pc_addr = 16'h0301; inst_ready = 1'b1;
    adv();
    inst_ready = 1'b0; mem_req_ready = 1'b1; halt = 1'b1;
    adv();
    mem_req_ready = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b1 || mem_req_addr !== 16'h0301 || inst !== 32'h1111_2222) begin
      errors++; $display("FAIL rm_pre busy %b addr %h inst %h exp 1 0301 11112222", busy, mem_req_addr, inst);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({busy, mem_req_valid, incPC, inst_valid} !== 4'b0000 || {mem_req_addr, inst, inst_pc} !== 64'h0) begin
      errors++; $display("FAIL rm_async flags %b data %h/%h/%h exp all 0", {busy, mem_req_valid, incPC, inst_valid}, mem_req_addr, inst, inst_pc);
    end
    adv();
    reset = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h3333_4444;
    #1;
    checks++;
    if (incPC !== 1'b0) begin
      errors++; $display("FAIL rm_stray inc got %b exp 0", incPC);
    end
    adv();
    mem_rsp_valid = 1'b0;
    #1;
    checks++;
    if (inst_valid !== 1'b0 || busy !== 1'b0 || inst !== 32'h0) begin
      errors++; $display("FAIL rm_after v %b busy %b inst %h exp 0 0 0", inst_valid, busy, inst);
    end
  endtask

  // Randomized run: PC register, single-outstanding memory and stalling decoder modelled here.
  task automatic test_random();
    logic [AW-1:0] model_pc;
    logic [AW-1:0] pend_addr;
    logic [AW-1:0] hold_pc;
    logic [IW-1:0] hold_inst;
    logic          pending, live, held, exp_inc, accept;
    int            delay, deliveries;
    do_reset();
    model_pc = 16'hFFF0; pend_addr = 16'h0; hold_pc = 16'h0; hold_inst = 32'h0;
    pending = 1'b0; live = 1'b0; held = 1'b0; delay = 0; deliveries = 0;
    halt = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      pc_addr = model_pc;
      if ($urandom_range(0, 19) == 0) halt = ~halt;
      flush = ($urandom_range(0, 15) == 0);
      mem_req_ready = ($urandom_range(0, 2) != 0);
      inst_ready = $urandom_range(0, 1) == 1;
      mem_rsp_valid = pending && (delay == 0);
      mem_rsp_data = mem_rsp_valid ? mem_word(pend_addr) : $urandom;
      #1;
      exp_inc = live && mem_rsp_valid && !flush;
      checks++;
      if (incPC !== exp_inc) begin
        errors++; $display("FAIL rnd_incPC cyc %0d got %b exp %b", cyc, incPC, exp_inc);
      end
      checks++;
      if (inst_valid !== held) begin
        errors++; $display("FAIL rnd_inst_valid cyc %0d got %b exp %b", cyc, inst_valid, held);
      end
      if (held) begin
        checks++;
        if (inst !== hold_inst || inst_pc !== hold_pc || mem_req_valid !== 1'b0) begin
          errors++; $display("FAIL rnd_hold cyc %0d inst %h pc %h req %b exp %h %h 0", cyc, inst, inst_pc, mem_req_valid, hold_inst, hold_pc);
        end
      end
      accept = mem_req_valid && mem_req_ready;
      if (accept) begin
        checks++;
        if (mem_req_addr !== model_pc || pending) begin
          errors++; $display("FAIL rnd_req cyc %0d addr %h exp %h outstanding %b", cyc, mem_req_addr, model_pc, pending);
        end
      end
      if (held && (flush || inst_ready)) begin
        if (!flush) deliveries++;
        held = 1'b0;
      end
      if (mem_rsp_valid) begin
        pending = 1'b0; live = 1'b0;
      end else if (pending) begin
        delay--;
      end
      if (flush) live = 1'b0;
      if (accept) begin
        pending = 1'b1; pend_addr = model_pc; delay = $urandom_range(0, 3); live = !flush;
      end
      if (exp_inc) begin
        held = 1'b1; hold_inst = mem_word(pend_addr); hold_pc = pend_addr;
        model_pc = model_pc + 16'd1;
      end
      if (flush) model_pc = ($urandom_range(0, 3) == 0) ? 16'hFFFE : AW'($urandom);
      adv();
    end
    idle_inputs();
    checks++;
    if (deliveries < 20) begin
      errors++; $display("FAIL rnd_progress deliveries %0d exp >= 20", deliveries);
    end
  endtask

  initial begin
    reset = 1'b0;
    pc_addr = 16'h0;
    idle_inputs();
    test_reset();
    test_zero_wait();
    test_backpressure();
    test_decoder_stall();
    test_flush_wait();
    test_flush_coincident();
    test_halt();
    test_reset_midop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
